// File: rtl/counter_sequencer_pkg.sv
// counter_sequencer_pkg: shared state encoding, default sizing and prescaler width helper
package counter_sequencer_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'b00, ST_RUN = 2'b01, ST_PAUSE = 2'b10, ST_HOLD = 2'b11} state_t;
  localparam int WIDTH = 5;
  localparam int PRESCALE = 4;
  function automatic int cnt_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/counter_sequencer_if.sv
// counter_sequencer_if: control commands in, count value and status out
interface counter_sequencer_if #(parameter int WIDTH = counter_sequencer_pkg::WIDTH);
  import counter_sequencer_pkg::*;
  logic start;
  logic pause;
  logic clear;
  logic auto_reload;
  logic [WIDTH-1:0] max_val;
  logic [WIDTH-1:0] value;
  logic busy;
  logic done;
  state_t state;
  modport master (output start, pause, clear, auto_reload, max_val, input value, busy, done, state);
  modport slave (input start, pause, clear, auto_reload, max_val, output value, busy, done, state);
endinterface

// File: rtl/counter_sequencer_tick_gen.sv
// tick_gen: prescaler producing one tick every PRESCALE enabled cycles
module tick_gen
  import counter_sequencer_pkg::*;
#(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int CW = cnt_w(PRESCALE);
  logic [CW-1:0] cnt;
  assign tick = en && cnt == CW'(PRESCALE - 1);
  always_ff @(posedge clk)
    cnt <= (!rst_n || clr || tick) ? '0 : en ? cnt + 1'b1 : cnt;
endmodule

// File: rtl/counter_sequencer.sv
// counter_sequencer: start/pause/resume/clear sequencing of a prescaled up-counter
module counter_sequencer
  import counter_sequencer_pkg::*;
#(
  parameter int WIDTH = counter_sequencer_pkg::WIDTH,
  parameter int PRESCALE = counter_sequencer_pkg::PRESCALE
) (
  input logic clk,
  input logic rst_n,
  counter_sequencer_if.slave bus
);
  state_t st, st_n;
  logic [WIDTH-1:0] val, val_n, lim, lim_n;
  logic done_q, done_n, run, tick, term;
  // a resume edge counts like any other RUN edge, so the prescaler advances on it
  assign run = !bus.clear && !bus.pause && (st == ST_RUN || (st == ST_PAUSE && bus.start));
  assign term = tick && val == lim;
  tick_gen #(.PRESCALE(PRESCALE)) u_tick (
    .clk(clk),
    .rst_n(rst_n),
    .en(run),
    .clr(bus.clear || st == ST_IDLE || st == ST_HOLD),
    .tick(tick)
  );
  always_comb begin
    st_n = st;
    val_n = val;
    lim_n = lim;
    done_n = 1'b0;
    if (bus.clear) begin
      st_n = ST_IDLE;
      val_n = '0;
    end else if (bus.pause) begin
      st_n = st == ST_RUN ? ST_PAUSE : st;
    end else if (bus.start && (st == ST_IDLE || st == ST_HOLD)) begin
      st_n = ST_RUN;
      val_n = '0;
      lim_n = bus.max_val;
    end else if (run) begin
      st_n = term && !bus.auto_reload ? ST_HOLD : ST_RUN;
      val_n = !tick ? val : !term ? val + 1'b1 : bus.auto_reload ? '0 : val;
      done_n = term;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st <= ST_IDLE;
      val <= '0;
      lim <= '0;
      done_q <= 1'b0;
    end else begin
      st <= st_n;
      val <= val_n;
      lim <= lim_n;
      done_q <= done_n;
    end
  end
  assign bus.value = val;
  assign bus.busy = st == ST_RUN || st == ST_PAUSE;
  assign bus.done = done_q;
  assign bus.state = st;
endmodule

// File: tb/tb_counter_sequencer.sv
// tb_counter_sequencer: directed scenarios checked against an elapsed-time model every cycle
module tb_counter_sequencer;
  import counter_sequencer_pkg::*;
  localparam int P = 4;
  logic clk = 0;
  logic rst_n = 0;
  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 0;
  int m_st = 0;
  int m_el = 0;
  int m_lim = 0;
  bit m_done = 0;
  counter_sequencer_if #(.WIDTH(5)) bus ();
  counter_sequencer #(.WIDTH(5), .PRESCALE(P)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  // model: count running edges since start; value is simply elapsed/PRESCALE
  always @(posedge clk) begin : mdl
    int st, el, lim;
    bit d;
    st = m_st;
    el = m_el;
    lim = m_lim;
    d = 0;
    if (!rst_n) begin
      st = 0;
      el = 0;
      lim = 0;
    end else if (bus.clear) begin
      st = 0;
      el = 0;
    end else if (bus.pause) begin
      st = st == 1 ? 2 : st;
    end else if (bus.start && (st == 0 || st == 3)) begin
      st = 1;
      el = 0;
      lim = int'(bus.max_val);
    end else if (st == 1 || (st == 2 && bus.start)) begin
      el = el + 1;
      st = 1;
      if (el == (lim + 1) * P) begin
        d = 1;
        if (bus.auto_reload) el = 0;
        else st = 3;
      end
    end
    m_st <= st;
    m_el <= el;
    m_lim <= lim;
    m_done <= d;
  end
  function automatic int exp_val();
    return m_st == 0 ? 0 : m_st == 3 ? m_lim : m_el / P;
  endfunction
  task automatic chk(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask
  always @(negedge clk) if (chk_en) begin
    chk("model.value", int'(bus.value), exp_val());
    chk("model.state", int'(bus.state), m_st);
    chk("model.busy", int'(bus.busy), int'(m_st == 1 || m_st == 2));
    chk("model.done", int'(bus.done), int'(m_done));
  end
  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic start_pulse(input int mv);
    bus.max_val = 5'(mv);
    bus.start = 1;
    @(negedge clk);
    bus.start = 0;
  endtask
  task automatic clear_pulse();
    bus.clear = 1;
    @(negedge clk);
    bus.clear = 0;
  endtask
  initial begin
    bus.start = 0;
    bus.pause = 0;
    bus.clear = 0;
    bus.auto_reload = 0;
    bus.max_val = 0;
    wait_n(2);
    rst_n = 1;
    chk_en = 1;
    chk("reset.value", int'(bus.value), 0);
    chk("reset.state", int'(bus.state), 0);
    chk("reset.busy", int'(bus.busy), 0);
    chk("reset.done", int'(bus.done), 0);
    // reset in the middle of a count
    start_pulse(3);
    wait_n(6);
    chk("pre_rst.value", int'(bus.value), 1);
    rst_n = 0;
    wait_n(2);
    rst_n = 1;
    chk("midrst.value", int'(bus.value), 0);
    chk("midrst.state", int'(bus.state), 0);
    chk("midrst.busy", int'(bus.busy), 0);
    chk("midrst.done", int'(bus.done), 0);
    // basic count to limit; max_val change after latch must not matter
    start_pulse(3);
    bus.max_val = 7;
    chk("run.state", int'(bus.state), 1);
    chk("run.value0", int'(bus.value), 0);
    for (int k = 1; k <= 3; k++) begin
      wait_n(4);
      chk("run.value", int'(bus.value), k);
    end
    wait_n(3);
    chk("run.predone", int'(bus.done), 0);
    wait_n(1);
    chk("run.done", int'(bus.done), 1);
    chk("hold.state", int'(bus.state), 3);
    chk("hold.value", int'(bus.value), 3);
    wait_n(1);
    chk("hold.done_off", int'(bus.done), 0);
    // pause on RUN edge 6 for 10 edges, then resume from HOLD-started run
    start_pulse(3);
    wait_n(5);
    chk("pause.before", int'(bus.value), 1);
    bus.pause = 1;
    wait_n(10);
    chk("pause.state", int'(bus.state), 2);
    chk("pause.value", int'(bus.value), 1);
    chk("pause.busy", int'(bus.busy), 1);
    bus.pause = 0;
    bus.start = 1;
    wait_n(1);
    bus.start = 0;
    wait_n(1);
    chk("resume.r1", int'(bus.value), 1);
    wait_n(1);
    chk("resume.r2", int'(bus.value), 2);
    clear_pulse();
    chk("clr.state", int'(bus.state), 0);
    // auto-reload periodic run
    bus.auto_reload = 1;
    start_pulse(2);
    for (int p = 0; p < 3; p++) begin
      wait_n(4);
      chk("ar.v1", int'(bus.value), 1);
      wait_n(4);
      chk("ar.v2", int'(bus.value), 2);
      wait_n(4);
      chk("ar.done", int'(bus.done), 1);
      chk("ar.v0", int'(bus.value), 0);
      chk("ar.state", int'(bus.state), 1);
    end
    bus.auto_reload = 0;
    // clear beats pause; pause beats start
    start_pulse(5);
    wait_n(5);
    bus.clear = 1;
    bus.pause = 1;
    wait_n(1);
    bus.clear = 0;
    bus.pause = 0;
    chk("clrpause.state", int'(bus.state), 0);
    chk("clrpause.value", int'(bus.value), 0);
    chk("clrpause.done", int'(bus.done), 0);
    bus.start = 1;
    bus.pause = 1;
    wait_n(1);
    bus.start = 0;
    bus.pause = 0;
    chk("startpause.state", int'(bus.state), 0);
    // limits 0 and 31
    start_pulse(0);
    wait_n(3);
    chk("max0.predone", int'(bus.done), 0);
    wait_n(1);
    chk("max0.done", int'(bus.done), 1);
    chk("max0.state", int'(bus.state), 3);
    chk("max0.value", int'(bus.value), 0);
    start_pulse(31);
    wait_n(124);
    chk("max31.value", int'(bus.value), 31);
    chk("max31.state", int'(bus.state), 1);
    wait_n(4);
    chk("max31.done", int'(bus.done), 1);
    chk("max31.hold", int'(bus.state), 3);
    chk("max31.held", int'(bus.value), 31);
    wait_n(1);
    chk("max31.nowrap", int'(bus.value), 31);
    chk("max31.done_off", int'(bus.done), 0);
    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
